// File: rtl/trace_dump_unit_pkg.sv
// ---------------------------------------------------------------------------
// dump_pkg
// Shared definitions for the trace dump unit: record tags for the two counter
// headers and the dump FSM state encoding.
// ---------------------------------------------------------------------------
package dump_pkg;

  // Record tags 0..NREG-1 carry register indices; the counters use tags
  // above the largest register index so a consumer can tell them apart.
  localparam logic [5:0] TAG_CYC = 6'd32;
  localparam logic [5:0] TAG_INS = 6'd33;

  typedef enum logic [2:0] {
    IDLE,
    HDR_CYC,
    HDR_INS,
    REG,
    FIN
  } state_t;

endpackage

// File: rtl/trace_dump_unit_perf_counters.sv
// ---------------------------------------------------------------------------
// perf_counters
// Free-running cycle counter and retired-instruction counter, plus a
// snapshot register that freezes the instruction count when a dump starts.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   instr_retired  : one-cycle pulse per retired instruction
//   capture        : latch the current (pre-increment) instruction count
//   cycle_cnt      : live cycle count, wraps modulo 2^CNT_W
//   ins_snap       : instruction count captured on the last capture pulse
// ---------------------------------------------------------------------------
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_retired,
  input  logic             capture,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] ins_snap
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] instr_cnt;

  // Both counters keep running while a dump is streaming out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (instr_retired) begin
        instr_cnt <= instr_cnt + CNT_ONE;
      end
    end
  end

  // The snapshot takes the value before this cycle's increment, so an
  // instruction retiring in the request cycle is not part of the dump.
  always_ff @(posedge clk) begin
    if (capture) begin
      ins_snap <= instr_cnt;
    end
  end

endmodule

// File: rtl/trace_dump_unit.sv
// ---------------------------------------------------------------------------
// trace_dump_unit
// Counts cycles and retired instructions and, on request, streams a record
// for each counter followed by one record per architectural register over a
// valid/ready port.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   instr_retired  : one-cycle pulse per retired instruction
//   dump_req       : start a dump (only honoured when no dump is running)
//   rf_raddr       : register-file read address (combinational read port)
//   rf_rdata       : register-file read data for rf_raddr, same cycle
//   out_valid      : record valid
//   out_ready      : consumer accepts record
//   out_tag        : register index, TAG_CYC or TAG_INS
//   out_data       : record payload, counters zero-extended
//   busy           : dump in progress
//   done           : one-cycle pulse after the final record is accepted
// ---------------------------------------------------------------------------
module trace_dump_unit
  import dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_retired,
  input  logic                    dump_req,
  output logic [$clog2(NREG)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5:0]              out_tag,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int                 IDX_W    = $clog2(NREG);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NREG - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  state_t             state;
  state_t             state_d;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   idx_nxt;
  logic               valid_d;
  logic [5:0]         tag_d;
  logic [DATA_W-1:0]  data_d;
  logic               capture;
  logic               handshake;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   ins_snap;

  function automatic logic [DATA_W-1:0] zext_cnt(input logic [CNT_W-1:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [5:0] reg_tag(input logic [IDX_W-1:0] i);
    return 6'(i);
  endfunction

  perf_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk           (clk),
    .rst           (rst),
    .instr_retired (instr_retired),
    .capture       (capture),
    .cycle_cnt     (cycle_cnt),
    .ins_snap      (ins_snap)
  );

  assign handshake = out_valid & out_ready;
  assign idx_nxt   = idx + IDX_ONE;

  // The record is held in the output register, so tag/data only change on a
  // handshake or when a new dump loads its first record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      out_valid <= valid_d;
      out_tag   <= tag_d;
      out_data  <= data_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    valid_d  = out_valid;
    tag_d    = out_tag;
    data_d   = out_data;
    capture  = 1'b0;
    rf_raddr = '0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state)
      // FIN pulses done and is otherwise idle, so a request arriving in the
      // completion cycle starts the next dump without a dead cycle.
      IDLE, FIN: begin
        done    = (state == FIN);
        state_d = IDLE;
        if (dump_req) begin
          capture = 1'b1;
          valid_d = 1'b1;
          tag_d   = TAG_CYC;
          data_d  = zext_cnt(cycle_cnt);
          state_d = HDR_CYC;
        end
      end

      HDR_CYC: begin
        busy = 1'b1;
        if (handshake) begin
          tag_d   = TAG_INS;
          data_d  = zext_cnt(ins_snap);
          state_d = HDR_INS;
        end
      end

      // Register 0 is addressed a cycle early so its value is ready to load
      // on the instruction-count handshake.
      HDR_INS: begin
        busy     = 1'b1;
        rf_raddr = '0;
        if (handshake) begin
          tag_d   = reg_tag('0);
          data_d  = rf_rdata;
          idx_d   = '0;
          state_d = REG;
        end
      end

      // While record idx is presented, the read port already points at the
      // next register so the following record loads on the handshake.
      REG: begin
        busy     = 1'b1;
        rf_raddr = (idx == LAST_IDX) ? '0 : idx_nxt;
        if (handshake) begin
          if (idx == LAST_IDX) begin
            valid_d = 1'b0;
            state_d = FIN;
          end else begin
            tag_d  = reg_tag(idx_nxt);
            data_d = rf_rdata;
            idx_d  = idx_nxt;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trace_dump_unit.sv
module tb_trace_dump_unit;

  localparam int DATA_W  = 32;
  localparam int NREG    = 32;
  localparam int CNT_W   = 4;
  localparam int NREC    = NREG + 2;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef struct packed {
    logic [5:0]        tag;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_retired;
  logic              dump_req;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_tag;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf [NREG];

  int   vectors      = 0;
  int   miscompares  = 0;
  int   cyc          = 0;
  int   t0           = 0;
  int   rec0         = 0;
  int   n_rec        = 0;
  int   rd_ptr       = 0;
  int   flush_to     = 0;
  int   last_pop_cyc = -1;
  int   rdy_mode     = 0;
  bit   done_due     = 1'b0;
  int   m_cyc        = 0;
  int   m_ins        = 0;
  rec_t exp_q[$];

  trace_dump_unit #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_retired (instr_retired),
    .dump_req      (dump_req),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_tag       (out_tag),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done)
  );

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [5:0] t, input logic [DATA_W-1:0] d);
    rec_t r;
    r.tag  = t;
    r.data = d;
    return r;
  endfunction

  // Reference model: a dump is a list of records computed at request time.
  initial begin : model
    int rp;
    int outst;
    forever begin
      @(posedge clk);
      rp    = (rd_ptr > flush_to) ? rd_ptr : flush_to;
      outst = exp_q.size() - rp;
      if (rst) begin
        m_cyc    = 0;
        m_ins    = 0;
        flush_to = exp_q.size();
      end else begin
        if (dump_req && outst == 0 && last_pop_cyc != cyc) begin
          exp_q.push_back(mk(6'd32, DATA_W'(m_cyc)));
          exp_q.push_back(mk(6'd33, DATA_W'(m_ins)));
          for (int i = 0; i < NREG; i++) exp_q.push_back(mk(6'(i), rf[i]));
        end
        m_cyc = (m_cyc + 1) % CNT_MOD;
        if (instr_retired) m_ins = (m_ins + 1) % CNT_MOD;
      end
    end
  end

  // Monitor: compares the presented record with the head of the queue.
  initial begin : monitor
    int outst;
    forever begin
      @(negedge clk);
      if (rd_ptr < flush_to) rd_ptr = flush_to;
      if (rst !== 1'b0) begin
        done_due = 1'b0;
      end else begin
        outst = exp_q.size() - rd_ptr;
        chk("busy", busy, outst != 0);
        chk("out_valid", out_valid, outst != 0);
        chk("done", done, done_due);
        done_due = 1'b0;
        if (out_valid === 1'b1 && outst != 0) begin
          chk("rec_tag", out_tag, exp_q[rd_ptr].tag);
          chk("rec_data", out_data, exp_q[rd_ptr].data);
          if (out_ready) begin
            rd_ptr++;
            n_rec++;
            if (rd_ptr == exp_q.size()) begin
              done_due     = 1'b1;
              last_pop_cyc = cyc;
            end
          end
        end
      end
    end
  end

  initial begin : ready_gen
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = ((cyc - t0) % 2 == 0);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_dump(input logic ins);
    step();
    dump_req      = 1'b1;
    instr_retired = ins;
    t0            = cyc;
    rec0          = n_rec;
    step();
    dump_req      = 1'b0;
    instr_retired = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat, input bit rand_ins);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      step();
      if (rand_ins) instr_retired = 1'($urandom_range(0, 1));
    end
    instr_retired = 1'b0;
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_nrec"}, n_rec - rec0, NREC);
    if (lat > 0) chk({nm, "_latency"}, cyc - t0, lat);
  endtask

  initial begin : driver
    int gap;
    rst           = 1'b1;
    instr_retired = 1'b0;
    dump_req      = 1'b0;
    for (int i = 0; i < NREG; i++) rf[i] = 32'h1000 + i;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_tag", out_tag, 6'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rf_raddr", rf_raddr, 5'd0);

    // 10 idle cycles with 4 retirements, request in cycle 10.
    for (int c = 0; c <= 10; c++) begin
      step();
      rst           = 1'b0;
      instr_retired = (c == 2 || c == 4 || c == 6 || c == 8);
      dump_req      = (c == 10);
      if (c == 10) begin
        t0   = cyc;
        rec0 = n_rec;
      end
    end
    step();
    dump_req      = 1'b0;
    instr_retired = 1'b0;
    @(negedge clk);
    chk("first_rec", {out_tag, out_data}, {6'd32, 32'd10});
    @(negedge clk);
    chk("second_rec", {out_tag, out_data}, {6'd33, 32'd4});
    wait_done("dump_full_rate", 35, 1'b0);

    // Alternating back-pressure.
    rdy_mode = 1;
    issue_dump(1'b0);
    wait_done("dump_toggle", 69, 1'b0);
    rdy_mode = 0;

    // Request coincident with a retirement at instruction count 7.
    step();
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      rst           = 1'b0;
      instr_retired = 1'b1;
    end
    issue_dump(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("coincide_ins", {out_tag, out_data}, {6'd33, 32'd7});
    wait_done("dump_coincide", 35, 1'b0);
    issue_dump(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("live_ins", {out_tag, out_data}, {6'd33, 32'd8});
    wait_done("dump_live", 35, 1'b0);

    // A second request during a dump is dropped.
    issue_dump(1'b0);
    repeat (4) step();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_done("dump_ignored", 35, 1'b0);

    // Reset in the middle of a dump, then restart immediately.
    issue_dump(1'b0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    dump_req = 1'b1;
    t0       = cyc;
    rec0     = n_rec;
    @(negedge clk);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    step();
    dump_req = 1'b0;
    @(negedge clk);
    chk("restart_rec", {out_tag, out_data}, {6'd32, 32'd0});
    wait_done("dump_restart", 35, 1'b0);

    // Randomised register contents, back-pressure and retirements.
    rdy_mode = 2;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREG; i++) rf[i] = $urandom;
      gap = $urandom_range(0, 6);
      repeat (gap) begin
        step();
        instr_retired = 1'($urandom_range(0, 1));
      end
      issue_dump(1'($urandom_range(0, 1)));
      wait_done("dump_rand", 0, 1'b1);
    end
    rdy_mode = 0;

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trace_dump_unit.md
# trace_dump_unit

Debug/observation stage sitting beside the CPU register file and directly upstream of the CPU testbench's reporting logic. It counts clock cycles and retired instructions and, on request, streams a snapshot of both counters followed by all architectural registers as tagged records over a valid/ready port. The bench consumes that stream instead of probing internal hierarchy.

## Interface
- `DATA_W`, 32: register and record data width
- `NREG`, 32: number of architectural registers dumped (indices 0..NREG-1)
- `CNT_W`, 32: width of cycle and instruction counters (must be ≤ DATA_W)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `instr_retired` in 1: one-cycle pulse per retired instruction
- `dump_req` in 1: request a dump; sampled only in IDLE
- `rf_raddr` out $clog2(NREG): register-file read address (combinational read port)
- `rf_rdata` in DATA_W: register-file read data, same cycle as `rf_raddr`
- `out_valid` out 1: record valid
- `out_ready` in 1: consumer accepts record
- `out_tag` out 6: 0..NREG-1 register index; 32 = cycle count; 33 = instruction count
- `out_data` out DATA_W: record payload (counters zero-extended)
- `busy` out 1: dump in progress
- `done` out 1: one-cycle pulse after final record accepted

## Operation
- Reset: `cycle_cnt`=0, `instr_cnt`=0, state IDLE; `out_valid`=0, `out_tag`=0, `out_data`=0, `busy`=0, `done`=0, `rf_raddr`=0.
- `cycle_cnt` increments every clock with `rst` low; `instr_cnt` increments on each `instr_retired`. Both wrap modulo 2^CNT_W and keep counting during a dump.
- States: IDLE → HDR_CYC → HDR_INS → REG → FIN → IDLE.
- IDLE, `dump_req`=1: snapshot `cycle_cnt` and `instr_cnt` (pre-increment values of that cycle; a coincident `instr_retired` is excluded), load record {32, cycle snapshot}, go HDR_CYC.
- HDR_CYC: on handshake load {33, instr snapshot}, go HDR_INS.
- HDR_INS: on handshake load {0, rf_rdata @ rf_raddr=0}, idx=0, go REG.
- REG: `rf_raddr`=idx+1 while waiting; on handshake, if idx=NREG-1 clear `out_valid`, go FIN; else load {idx+1, rf_rdata}, idx++.
- FIN: assert `done` one cycle, go IDLE.
- Register values are sampled at record load time, not at the request; the CPU must be halted for a coherent dump.
- Output record is registered: `out_tag`/`out_data` stable while `out_valid` && !`out_ready`.
- `dump_req` outside IDLE is ignored (not queued). `rst` mid-dump aborts immediately: reset values next cycle, no `done`.

## Timing
- `dump_req` in cycle T → `out_valid`=1, `busy`=1 at T+1 with tag 32.
- With `out_ready` held 1: one record per cycle, tags 32,33,0..NREG-1 in cycles T+1..T+NREG+2; `done`=1 and `busy`=0 at T+NREG+3; new `dump_req` accepted from T+NREG+3.
- Back-pressure adds exactly one cycle per cycle of `out_ready`=0 while valid; no record dropped or duplicated.
- `busy` high from T+1 through the cycle of the final handshake.

## Structure
- Shared package `dump_pkg`: `TAG_CYC`=6'd32, `TAG_INS`=6'd33, state enum (IDLE, HDR_CYC, HDR_INS, REG, FIN).
- Sub-module `perf_counters`: cycle and instruction counters with snapshot-capture input; dump FSM and output register in the top.

## Test plan
- Reset then 10 idle cycles, 4 `instr_retired` pulses, `dump_req` at cycle 10 → first record {32, 10}, then {33, 4}, `out_ready`=1 throughout.
- Register file preloaded R[i]=0x1000+i, `out_ready`=1 → 34 consecutive records, R31 record {31, 0x101F}, `done` at T+35, `busy` low same cycle.
- `out_ready` toggled 0/1 each cycle → 34 records in order, payload stable during stalls, completion at T+69.
- `dump_req` and `instr_retired` in same cycle with `instr_cnt`=7 → instruction record 7, live counter 8.
- Second `dump_req` at T+5 → ignored, exactly 34 records; `rst` at T+10 → `out_valid`=0, counters 0, no `done`.
- Counters preset near 2^CNT_W-1 (via forced state or CNT_W=4 build) → wrap to 0, snapshot shows wrapped value.
